lwe_inner_product: RTL
======================

LWE_INNER_PRODUCT -- requirements
Module: lwe_inner_product

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of a-coefficients, message, noise and result (signed two's complement).
REQ-002 SHALL have parameter N_WIDTH, default 8, width of vector-length input and element counter.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin one LWE body computation; sampled only in IDLE.
REQ-006 SHALL have port n  input  N_WIDTH  number of (a, s) pairs; latched on accepted start.
REQ-007 SHALL have port a_valid  input  1  a_data/s_bit valid this cycle.
REQ-008 SHALL have port a_data  input  DATA_WIDTH signed  mask coefficient a_i.
REQ-009 SHALL have port s_bit  input  1  binary secret-key bit s_i.
REQ-010 SHALL have port a_ready  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port mu  input  DATA_WIDTH signed  encoded message; sampled in ADD.
REQ-012 SHALL have port e  input  DATA_WIDTH signed  Gaussian noise sample; sampled in ADD.
REQ-013 SHALL have port m_out  output  DATA_WIDTH signed  b = sum(a_i*s_i) + mu + e, fed to the downstream modulo reducer.
REQ-014 SHALL have port mod_start  output  1  one-cycle start pulse to downstream reducer.
REQ-015 SHALL have port mod_done  input  1  downstream reduction complete.
REQ-016 SHALL have ports busy  output  1  (state != IDLE) and done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, ADD, ISSUE, WAIT, DONE.
REQ-018 IDLE: start=1 and n!=0 -> latch n, clear acc and count, go ACCUM; start=1 and n==0 -> clear acc, go ADD; else stay.
REQ-019 ACCUM: a_ready=1; on a_valid&a_ready: acc <= acc + (s_bit ? a_data : 0), count <= count+1; on acceptance with count==n-1 go ADD.
REQ-020 a_valid=0 in ACCUM SHALL stall with acc and count unchanged; no timeout.
REQ-021 a_ready SHALL be 0 in every state other than ACCUM; a_valid outside ACCUM is ignored.
REQ-022 ADD: acc <= acc + mu + e in a single cycle, then go ISSUE.
REQ-023 All additions SHALL be DATA_WIDTH-bit two's complement with silent wrap-around (mod 2^DATA_WIDTH); no saturation, no overflow flag.
REQ-024 m_out SHALL equal acc continuously; acc SHALL be stable in ISSUE, WAIT and DONE.
REQ-025 ISSUE: mod_start=1 for exactly this cycle, then go WAIT.
REQ-026 WAIT: mod_start=0; on mod_done=1 go DONE; mod_done outside WAIT SHALL be ignored.
REQ-027 DONE: done=1 for exactly one cycle, then go IDLE; m_out holds the result until the next accepted start.
REQ-028 start asserted outside IDLE SHALL be ignored; start and mod_done in the same cycle SHALL not interact.
REQ-029 Latency with continuous a_valid: start sampled at edge T -> mod_start high in cycle T+n+2 (n>=1), T+2 for n=0.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, acc=0, count=0, latched n=0; outputs a_ready=0, m_out=0, mod_start=0, busy=0, done=0.
REQ-031 Reset asserted in any state, including ACCUM or WAIT, SHALL abort the computation with no done or mod_start pulse; operation resumes only on a new start after rst=1.

Verification
REQ-032 n=4, a={5,-3,7,2}, s={1,1,0,1}, mu=10, e=-1, a_valid always 1 -> m_out=13, mod_start 6 cycles after start edge, done 1 cycle after mod_done.
REQ-033 n=0, mu=100, e=-7 -> no a_ready assertion, m_out=93, mod_start 2 cycles after start.
REQ-034 DATA_WIDTH=32, n=2, a={0x7FFFFFFF,0x7FFFFFFF}, s={1,1}, mu=0, e=0 -> m_out=0xFFFFFFFE (-2), wrap with no error.
REQ-035 n=3 with a_valid low for 5 cycles between pairs, plus start and a_valid pulses during WAIT -> correct sum, busy stays 1, extra start ignored.
REQ-036 rst pulsed low during WAIT with mod_done later asserted -> all outputs 0, no done; a following start with n=1, a=4, s=1, mu=0, e=0 -> m_out=4.

Source files
------------

// File: rtl/lwe_inner_product.sv
// LWE body generator: accumulates sum(a_i * s_i) over a streamed mask vector,
// adds message and noise, then hands the result to a downstream modulo reducer.
module lwe_inner_product #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_WIDTH-1:0]           n,
  input  logic                         a_valid,
  input  logic signed [DATA_WIDTH-1:0] a_data,
  input  logic                         s_bit,
  output logic                         a_ready,
  input  logic signed [DATA_WIDTH-1:0] mu,
  input  logic signed [DATA_WIDTH-1:0] e,
  output logic signed [DATA_WIDTH-1:0] m_out,
  output logic                         mod_start,
  input  logic                         mod_done,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_ADD   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [N_WIDTH-1:0]             count_q, count_d;
  logic [N_WIDTH-1:0]             n_q, n_d;
  logic                           a_ready_q, mod_start_q, busy_q, done_q;

  // State and datapath registers; strobes are registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      n_q         <= '0;
      a_ready_q   <= 1'b0;
      mod_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      n_q         <= n_d;
      a_ready_q   <= (state_d == S_ACCUM);
      mod_start_q <= (state_d == S_ISSUE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  // Next-state and datapath update; all sums wrap modulo 2^DATA_WIDTH
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          n_d     = n;
          state_d = (n != '0) ? S_ACCUM : S_ADD;
        end
      end
      S_ACCUM: begin
        if (a_valid && a_ready_q) begin
          acc_d   = acc_q + (s_bit ? a_data : '0);
          count_d = count_q + N_WIDTH'(1);
          if (count_q == n_q - N_WIDTH'(1)) begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        acc_d   = acc_q + mu + e;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mod_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a_ready   = a_ready_q;
  assign mod_start = mod_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m_out     = acc_q;

endmodule
